// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle DIV/DIVU unit: launches, stalls, cancels, captures HI/LO.
// Optional watchdog abort enabled by defining DIV_TIMEOUT_EN.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic        annul_q, annul_d;
    logic        signed_q, signed_d;
    logic        hilo_we_q, hilo_we_d;
    logic        timeout_q, timeout_d;
    logic [31:0] opdata1_q, opdata1_d;
    logic [31:0] opdata2_q, opdata2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        stall_req;
    logic        timeout_hit;

`ifdef DIV_TIMEOUT_EN
    logic [5:0] wait_cnt_q, wait_cnt_d;

    // Counter is zero on the first WAIT cycle, so the last allowed cycle is TIMEOUT_CYCLES-1.
    always_comb begin
        wait_cnt_d = 6'd0;
        if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 6'd1;
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == 6'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 6'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        annul_d   = 1'b0;
        signed_d  = signed_q;
        opdata1_d = opdata1_q;
        opdata2_d = opdata2_q;
        hilo_we_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        timeout_d = timeout_q;
        stall_req = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (div_req_i && !flush_i) begin
                    stall_req = 1'b1;
                    opdata1_d = rs_data_i;
                    opdata2_d = rt_data_i;
                    signed_d  = div_signed_i;
                    start_d   = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_req = 1'b1;
                // Flush outranks a same-cycle result: the instruction is squashed.
                if (flush_i) begin
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end else if (div_ready_i) begin
                    stall_req = 1'b0;
                    hi_d      = div_result_i[63:32];
                    lo_d      = div_result_i[31:0];
                    hilo_we_d = 1'b1;
                    start_d   = 1'b0;
                    state_d   = S_RELEASE;
                end else if (timeout_hit) begin
                    stall_req = 1'b0;
                    annul_d   = 1'b1;
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                    hi_d      = 32'd0;
                    lo_d      = 32'd0;
                    hilo_we_d = 1'b1;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Divider frees itself on this edge; a queued divide issues next cycle.
                stall_req = div_req_i;
                start_d   = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            signed_q  <= 1'b0;
            opdata1_q <= 32'd0;
            opdata2_q <= 32'd0;
            hilo_we_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            annul_q   <= annul_d;
            signed_q  <= signed_d;
            opdata1_q <= opdata1_d;
            opdata2_q <= opdata2_d;
            hilo_we_q <= hilo_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            timeout_q <= timeout_d;
        end
    end

    assign div_start_o   = start_q;
    assign div_annul_o   = annul_q;
    assign div_signed_o  = signed_q;
    assign div_opdata1_o = opdata1_q;
    assign div_opdata2_o = opdata2_q;
    assign stall_req_o   = stall_req;
    assign hilo_we_o     = hilo_we_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_timeout_o = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, HI/LO scoreboard, directed handshake scenarios.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_req_i = 1'b0;
    logic        div_signed_i = 1'b0;
    logic [31:0] rs_data_i = 32'd0;
    logic [31:0] rt_data_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        stall_req_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;
    logic        div_timeout_o;

    int          n_total = 0;
    int          n_bad = 0;
    int          n_we = 0;
    int          n_pushed = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_a, cur_b;
    logic        cur_s;

    // Divider model state
    int          dv_state;
    int          dv_cnt;
    int          dv_lat = 6;
    bit          dv_never = 1'b0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TIMEOUT_CYCLES(48)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (div_req_i),
        .div_signed_i (div_signed_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .flush_i      (flush_i),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .stall_req_o  (stall_req_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_timeout_o(div_timeout_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Free=0, busy=1, done=2; result held while start stays high.
    always @(posedge clk) begin
        if (rst) begin
            dv_state     <= 0;
            dv_cnt       <= 0;
            div_ready_i  <= 1'b0;
            div_result_i <= 64'd0;
        end else begin
            case (dv_state)
                0: if (div_start_o && !div_annul_o) begin
                    dv_state     <= 1;
                    dv_cnt       <= dv_lat;
                    div_result_i <= ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);
                end
                1: if (div_annul_o) begin
                    dv_state <= 0;
                end else if (!dv_never) begin
                    if (dv_cnt <= 1) begin
                        div_ready_i <= 1'b1;
                        dv_state    <= 2;
                    end else begin
                        dv_cnt <= dv_cnt - 1;
                    end
                end
                default: if (!div_start_o) begin
                    div_ready_i <= 1'b0;
                    dv_state    <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && hilo_we_o) begin
            logic [63:0] e;
            n_we++;
            $display("txn %0d: hilo_we hi=%08h lo=%08h", n_we, hi_o, lo_o);
            if (exp_q.size() == 0) begin
                check_val("unexpected_hilo_we", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("hi", hi_o, e[63:32]);
                check_val("lo", lo_o, e[31:0]);
            end
        end
    end

    // Call just after a negedge in IDLE; returns at the negedge after the issue edge.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input bit do_push, input logic [63:0] exp);
        div_req_i    = 1'b1;
        div_signed_i = sg;
        rs_data_i    = a;
        rt_data_i    = b;
        cur_a = a; cur_b = b; cur_s = sg;
        if (do_push) begin
            exp_q.push_back(exp);
            n_pushed++;
        end
        #1 check_val("stall_on_request", stall_req_o, 1);
        @(negedge clk);
        check_val("start_issued", div_start_o, 1);
        check_val("opdata1", div_opdata1_o, a);
        check_val("opdata2", div_opdata2_o, b);
        check_val("signed", div_signed_o, sg);
        rs_data_i    = ~a;
        rt_data_i    = ~b;
        div_signed_i = ~sg;
    endtask

    task automatic wait_ready();
        int  n = 0;
        bit  stall_bad = 1'b0;
        while (!div_ready_i && n < 200) begin
            if (stall_req_o !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check_val("stall_while_wait", stall_bad, 0);
        if (n >= 200) begin
            check_val("ready_seen", 0, 1);
        end else begin
            check_val("stall_in_ready_cycle", stall_req_o, 0);
            check_val("start_held", div_start_o, 1);
            check_val("op1_held", div_opdata1_o, cur_a);
            check_val("op2_held", div_opdata2_o, cur_b);
            check_val("signed_held", div_signed_o, cur_s);
        end
    endtask

    task automatic finish_txn();
        @(negedge clk);
        div_req_i = 1'b0;
        #1;
        check_val("we_pulse", hilo_we_o, 1);
        check_val("start_dropped", div_start_o, 0);
        check_val("stall_release_noreq", stall_req_o, 0);
        @(negedge clk);
        check_val("we_single_cycle", hilo_we_o, 0);
        check_val("annul_quiet", div_annul_o, 0);
    endtask

    task automatic expect_annul_pulse();
        @(negedge clk);
        flush_i   = 1'b0;
        div_req_i = 1'b0;
        check_val("annul_pulse", div_annul_o, 1);
        check_val("start_after_flush", div_start_o, 0);
        check_val("no_we_on_flush", hilo_we_o, 0);
        @(negedge clk);
        check_val("annul_one_cycle", div_annul_o, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_start", div_start_o, 0);
        check_val("rst_annul", div_annul_o, 0);
        check_val("rst_signed", div_signed_o, 0);
        check_val("rst_op1", div_opdata1_o, 0);
        check_val("rst_op2", div_opdata2_o, 0);
        check_val("rst_we", hilo_we_o, 0);
        check_val("rst_hilo", {hi_o, lo_o}, 0);
        check_val("rst_timeout", div_timeout_o, 0);
        check_val("rst_stall", stall_req_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Signed -7 / 2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_ready();
        finish_txn();

        // Unsigned 100 / 7
        issue(1'b0, 32'd100, 32'd7, 1, {32'd2, 32'd14});
        wait_ready();
        finish_txn();

        // Divide by zero
        issue(1'b0, 32'h1234_5678, 32'd0, 1, 64'd0);
        wait_ready();
        finish_txn();
        check_val("timeout_clear_div0", div_timeout_o, 0);

        // Flush mid-computation, then a normal divide
        dv_lat = 20;
        issue(1'b0, 32'd1000, 32'd3, 0, 64'd0);
        repeat (9) @(negedge clk);
        check_val("stall_before_flush", stall_req_o, 1);
        flush_i = 1'b1;
        expect_annul_pulse();
        dv_lat = 6;
        issue(1'b0, 32'd1000, 32'd3, 1, {32'd1, 32'd333});
        wait_ready();
        finish_txn();

        // Flush coincident with ready
        issue(1'b0, 32'd9, 32'd4, 0, 64'd0);
        wait_ready();
        flush_i = 1'b1;
        expect_annul_pulse();

        // Request arriving together with flush in IDLE is ignored
        div_req_i = 1'b1;
        flush_i   = 1'b1;
        #1 check_val("stall_req_with_flush", stall_req_o, 0);
        @(negedge clk);
        check_val("no_issue_on_flush", div_start_o, 0);
        div_req_i = 1'b0;
        flush_i   = 1'b0;
        @(negedge clk);

        // Back-to-back 100/7 then 50/5 with request held
        issue(1'b0, 32'd100, 32'd7, 1, {32'd2, 32'd14});
        wait_ready();
        @(negedge clk);
        rs_data_i = 32'd50;
        rt_data_i = 32'd5;
        div_signed_i = 1'b0;
        cur_a = 32'd50; cur_b = 32'd5; cur_s = 1'b0;
        exp_q.push_back({32'd0, 32'd10});
        n_pushed++;
        #1;
        check_val("b2b_we", hilo_we_o, 1);
        check_val("b2b_stall_release", stall_req_o, 1);
        check_val("b2b_start_low", div_start_o, 0);
        @(negedge clk);
        check_val("b2b_no_issue_in_release", div_start_o, 0);
        check_val("b2b_stall_idle", stall_req_o, 1);
        @(negedge clk);
        check_val("b2b_second_start", div_start_o, 1);
        check_val("b2b_second_op1", div_opdata1_o, 32'd50);
        check_val("b2b_second_op2", div_opdata2_o, 32'd5);
        wait_ready();
        finish_txn();

`ifdef DIV_TIMEOUT_EN
        begin
            int n;
            dv_never = 1'b1;
            issue(1'b0, 32'd77, 32'd7, 1, 64'd0);
            n = 1;
            while (!div_annul_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_val("timeout_latency", n, 49);
            check_val("timeout_flag", div_timeout_o, 1);
            check_val("timeout_we", hilo_we_o, 1);
            @(negedge clk);
            div_req_i = 1'b0;
            check_val("timeout_annul_once", div_annul_o, 0);
            repeat (3) @(negedge clk);
            check_val("timeout_sticky", div_timeout_o, 1);
            dv_never = 1'b0;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check_val("timeout_cleared_by_rst", div_timeout_o, 0);
            rst = 1'b0;
            @(negedge clk);
        end
`else
        check_val("timeout_tied_low", div_timeout_o, 0);
`endif

        repeat (3) @(negedge clk);
        check_val("we_count", n_we, n_pushed);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
